// File: rtl/vga_timing_pkg.sv
// Shared phase encodings, 640x480@60 default timing and raster-total helpers
// for the VGA timing controller.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    HS_ACT = 2'd0,
    HS_FP  = 2'd1,
    HS_SYN = 2'd2,
    HS_BP  = 2'd3
  } h_phase_t;

  typedef enum logic [1:0] {
    VS_ACT = 2'd0,
    VS_FP  = 2'd1,
    VS_SYN = 2'd2,
    VS_BP  = 2'd3
  } v_phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_DIV      = 2;

  function automatic int h_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides in_clk by DIV into a one-cycle pixel-enable pulse; the divider
// restarts from zero whenever run is low so the first tick lands DIV cycles in.
module pixel_tick_gen #(
  parameter int DIV = 2
) (
  input  logic in_clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic          tick_reg;

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (!run) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= (cnt_reg == LAST);
      cnt_reg  <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel tick, horizontal/vertical phase FSMs and
// frame-aligned start/stop. Define VGA_TIMING_REG_OUT_EN for a one-pixel output register stage.
module vga_timing_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int DIV      = DEF_DIV,
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          in_clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          running
);

  h_phase_t      h_state_reg, h_state_next;
  v_phase_t      v_state_reg, v_state_next;
  logic [XW-1:0] h_cnt_reg, h_cnt_next, x_reg, x_next;
  logic [YW-1:0] v_cnt_reg, v_cnt_next, y_reg, y_next;
  logic          running_reg, running_next;
  logic          tick, pix_tick_int, h_wrap, v_wrap, frame_end, stop_edge;
  logic          hsync_int, vsync_int, blank_int;

  pixel_tick_gen #(.DIV(DIV)) u_pixel_tick_gen (
    .in_clk(in_clk),
    .reset (reset),
    .run   (running_reg),
    .tick  (tick)
  );

  // Phase counters count down to zero; the phase ends on the tick seen at zero.
  assign pix_tick_int = tick & running_reg;
  assign h_wrap       = (h_state_reg == HS_BP) && (h_cnt_reg == '0);
  assign v_wrap       = (v_state_reg == VS_BP) && (v_cnt_reg == '0);
  assign frame_end    = pix_tick_int && h_wrap && v_wrap;
  assign stop_edge    = frame_end && !enable;

  always_comb begin
    h_state_next = h_state_reg;
    h_cnt_next   = h_cnt_reg;
    x_next       = x_reg;
    v_state_next = v_state_reg;
    v_cnt_next   = v_cnt_reg;
    y_next       = y_reg;
    running_next = running_reg;

    if (!running_reg)   running_next = enable;
    else if (stop_edge) running_next = 1'b0;

    if (pix_tick_int) begin
      x_next = h_wrap ? '0 : x_reg + XW'(1);
      if (h_cnt_reg != '0) begin
        h_cnt_next = h_cnt_reg - XW'(1);
      end else begin
        case (h_state_reg)
          HS_ACT: begin h_state_next = HS_FP;  h_cnt_next = XW'(H_FP - 1);     end
          HS_FP:  begin h_state_next = HS_SYN; h_cnt_next = XW'(H_SYNC - 1);   end
          HS_SYN: begin h_state_next = HS_BP;  h_cnt_next = XW'(H_BP - 1);     end
          HS_BP:  begin h_state_next = HS_ACT; h_cnt_next = XW'(H_ACTIVE - 1); end
        endcase
      end

      if (h_wrap) begin
        y_next = v_wrap ? '0 : y_reg + YW'(1);
        if (v_cnt_reg != '0) begin
          v_cnt_next = v_cnt_reg - YW'(1);
        end else begin
          case (v_state_reg)
            VS_ACT: begin v_state_next = VS_FP;  v_cnt_next = YW'(V_FP - 1);     end
            VS_FP:  begin v_state_next = VS_SYN; v_cnt_next = YW'(V_SYNC - 1);   end
            VS_SYN: begin v_state_next = VS_BP;  v_cnt_next = YW'(V_BP - 1);     end
            VS_BP:  begin v_state_next = VS_ACT; v_cnt_next = YW'(V_ACTIVE - 1); end
          endcase
        end
      end
    end
  end

  // A stop lands exactly on the raster wrap, which is also the reset state.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      h_state_reg <= HS_ACT;
      h_cnt_reg   <= XW'(H_ACTIVE - 1);
      x_reg       <= '0;
      v_state_reg <= VS_ACT;
      v_cnt_reg   <= YW'(V_ACTIVE - 1);
      y_reg       <= '0;
      running_reg <= 1'b0;
    end else begin
      h_state_reg <= h_state_next;
      h_cnt_reg   <= h_cnt_next;
      x_reg       <= x_next;
      v_state_reg <= v_state_next;
      v_cnt_reg   <= v_cnt_next;
      y_reg       <= y_next;
      running_reg <= running_next;
    end
  end

  assign hsync_int = (h_state_reg != HS_SYN);
  assign vsync_int = (v_state_reg != VS_SYN);
  assign blank_int = running_reg && (h_state_reg == HS_ACT) && (v_state_reg == VS_ACT);

`ifdef VGA_TIMING_REG_OUT_EN
  logic          hsync_reg, vsync_reg, blank_n_reg, fs_pend_reg;
  logic [XW-1:0] x_out_reg;
  logic [YW-1:0] y_out_reg;

  // fs_pend_reg remembers that the pixel now held in the output stage is (0,0).
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      blank_n_reg <= 1'b0;
      x_out_reg   <= '0;
      y_out_reg   <= '0;
      fs_pend_reg <= 1'b0;
    end else if (stop_edge) begin
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      blank_n_reg <= 1'b0;
      x_out_reg   <= '0;
      y_out_reg   <= '0;
      fs_pend_reg <= 1'b0;
    end else if (pix_tick_int) begin
      hsync_reg   <= hsync_int;
      vsync_reg   <= vsync_int;
      blank_n_reg <= blank_int;
      x_out_reg   <= x_reg;
      y_out_reg   <= y_reg;
      fs_pend_reg <= (x_reg == '0) && (y_reg == '0);
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign blank_n     = blank_n_reg;
  assign x           = x_out_reg;
  assign y           = y_out_reg;
  assign frame_start = pix_tick_int && fs_pend_reg;
`else
  assign hsync       = hsync_int;
  assign vsync       = vsync_int;
  assign blank_n     = blank_int;
  assign x           = x_reg;
  assign y           = y_reg;
  assign frame_start = pix_tick_int && (x_reg == '0) && (y_reg == '0);
`endif

  assign pix_tick = pix_tick_int;
  assign running  = running_reg;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller: two small rasters (DIV=2 and DIV=1)
// checked cycle by cycle against a closed-form raster model.
module tb_vga_timing_controller;

`ifdef VGA_TIMING_REG_OUT_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  localparam int A_DIV = 2, A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VA = 4, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int B_DIV = 1, B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VA = 2, B_VF = 2, B_VS = 2, B_VB = 2;

  localparam int U_DIV[2] = '{A_DIV, B_DIV};
  localparam int U_HA[2]  = '{A_HA, B_HA};
  localparam int U_HSB[2] = '{A_HA + A_HF, B_HA + B_HF};
  localparam int U_HSE[2] = '{A_HA + A_HF + A_HS, B_HA + B_HF + B_HS};
  localparam int U_HT[2]  = '{A_HA + A_HF + A_HS + A_HB, B_HA + B_HF + B_HS + B_HB};
  localparam int U_VA[2]  = '{A_VA, B_VA};
  localparam int U_VSB[2] = '{A_VA + A_VF, B_VA + B_VF};
  localparam int U_VSE[2] = '{A_VA + A_VF + A_VS, B_VA + B_VF + B_VS};
  localparam int U_VT[2]  = '{A_VA + A_VF + A_VS + A_VB, B_VA + B_VF + B_VS + B_VB};

  logic            in_clk = 1'b0;
  logic            reset;
  logic [1:0]      en;
  logic [1:0]      pt, hs, vs, bl, fs, rn;
  logic [1:0][3:0] xo;
  logic [1:0][2:0] yo;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int k[2], c0[2], fs_last[2], blank_cnt[2];
  bit run_exp[2], last_px[2];

  always #5 in_clk = ~in_clk;

  vga_timing_controller #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .DIV(A_DIV)
  ) dut_a (
    .in_clk(in_clk), .reset(reset), .enable(en[0]), .pix_tick(pt[0]),
    .hsync(hs[0]), .vsync(vs[0]), .blank_n(bl[0]), .x(xo[0]), .y(yo[0]),
    .frame_start(fs[0]), .running(rn[0])
  );

  vga_timing_controller #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .DIV(B_DIV)
  ) dut_b (
    .in_clk(in_clk), .reset(reset), .enable(en[1]), .pix_tick(pt[1]),
    .hsync(hs[1]), .vsync(vs[1]), .blank_n(bl[1]), .x(xo[1]), .y(yo[1]),
    .frame_start(fs[1]), .running(rn[1])
  );

  task automatic check_eq(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic check_idle(input int u, input string why);
    check_eq($sformatf("u%0d %s x", u, why), int'(xo[u]), 0);
    check_eq($sformatf("u%0d %s y", u, why), int'(yo[u]), 0);
    check_eq($sformatf("u%0d %s hsync", u, why), hs[u], 1);
    check_eq($sformatf("u%0d %s vsync", u, why), vs[u], 1);
    check_eq($sformatf("u%0d %s blank_n", u, why), bl[u], 0);
    check_eq($sformatf("u%0d %s frame_start", u, why), fs[u], 0);
  endtask

  // One clock edge; both units are compared against the raster model.
  task automatic tick_cycle();
    bit starting[2], stopping[2];
    for (int u = 0; u < 2; u++) begin
      starting[u] = !run_exp[u] && en[u] && reset;
      stopping[u] = run_exp[u] && last_px[u] && !en[u];
    end
    @(posedge in_clk);
    #1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      int idx, ex, ey, ehs, evs, ebl, efs, ft;
      bit pexp;
      if (!reset) run_exp[u] = 1'b0;
      else if (starting[u]) begin
        run_exp[u] = 1'b1; c0[u] = cyc; k[u] = 0; fs_last[u] = -1; blank_cnt[u] = 0;
      end else if (stopping[u]) run_exp[u] = 1'b0;
      last_px[u] = 1'b0;
      check_eq($sformatf("u%0d running", u), rn[u], int'(run_exp[u]));
      pexp = run_exp[u] && (cyc != c0[u]) && ((cyc - c0[u]) % U_DIV[u] == 0);
      check_eq($sformatf("u%0d pix_tick", u), pt[u], int'(pexp));
      if (!run_exp[u]) begin
        check_idle(u, "idle");
      end else if (pexp) begin
        ft  = U_HT[u] * U_VT[u];
        idx = k[u] - LAG;
        if (idx < 0) begin
          ex = 0; ey = 0; ehs = 1; evs = 1; ebl = 0; efs = 0;
        end else begin
          ex  = idx % U_HT[u];
          ey  = (idx / U_HT[u]) % U_VT[u];
          ehs = (ex >= U_HSB[u] && ex < U_HSE[u]) ? 0 : 1;
          evs = (ey >= U_VSB[u] && ey < U_VSE[u]) ? 0 : 1;
          ebl = (ex < U_HA[u] && ey < U_VA[u]) ? 1 : 0;
          efs = (idx % ft == 0) ? 1 : 0;
        end
        check_eq($sformatf("u%0d x", u), int'(xo[u]), ex);
        check_eq($sformatf("u%0d y", u), int'(yo[u]), ey);
        check_eq($sformatf("u%0d hsync x=%0d", u, ex), hs[u], ehs);
        check_eq($sformatf("u%0d vsync y=%0d", u, ey), vs[u], evs);
        check_eq($sformatf("u%0d blank_n", u), bl[u], ebl);
        check_eq($sformatf("u%0d frame_start", u), fs[u], efs);
        if (efs == 1) begin
          if (fs_last[u] >= 0) begin
            check_eq($sformatf("u%0d frame period", u), cyc - fs_last[u], ft * U_DIV[u]);
            check_eq($sformatf("u%0d active ticks", u), blank_cnt[u], U_HA[u] * U_VA[u]);
          end
          fs_last[u]   = cyc;
          blank_cnt[u] = 0;
        end
        if (bl[u]) blank_cnt[u]++;
        last_px[u] = (k[u] % ft == ft - 1);
        k[u]++;
      end else begin
        check_eq($sformatf("u%0d frame_start no tick", u), fs[u], 0);
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic wait_coord(input int u, input bit on_y, input int val, input int limit);
    int found = 0;
    for (int i = 0; i < limit && found == 0; i++) begin
      tick_cycle();
      if ((on_y ? int'(yo[u]) : int'(xo[u])) == val) found = 1;
    end
    check_eq($sformatf("u%0d reach %s=%0d", u, on_y ? "y" : "x", val), found, 1);
  endtask

  task automatic run_until_stop(input int u, input int limit);
    for (int i = 0; i < limit && rn[u] == 1'b1; i++) tick_cycle();
    check_eq($sformatf("u%0d stopped", u), rn[u], 0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      k[u] = 0; c0[u] = 0; fs_last[u] = -1; blank_cnt[u] = 0;
      run_exp[u] = 1'b0; last_px[u] = 1'b0;
    end
    reset = 1'b0;
    en    = 2'b00;

    $display("[tb] reset hold");
    run_cycles(3);
    reset = 1'b1;
    run_cycles(2);

    $display("[tb] start both units, continuous frames");
    en = 2'b11;
    run_cycles(600);

    $display("[tb] unit0: enable dropped at y=2, frame must complete");
    wait_coord(0, 1'b1, 2, 300);
    en[0] = 1'b0;
    run_until_stop(0, 300);
    run_cycles(10);

    $display("[tb] unit0: restart, drop at y=2, reassert at y=5");
    en[0] = 1'b1;
    wait_coord(0, 1'b1, 2, 300);
    en[0] = 1'b0;
    wait_coord(0, 1'b1, 5, 300);
    en[0] = 1'b1;
    run_cycles(600);

    $display("[tb] asynchronous reset mid-line at x=5");
    wait_coord(0, 1'b0, 5, 100);
    reset = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      check_eq($sformatf("u%0d async running", u), rn[u], 0);
      check_eq($sformatf("u%0d async pix_tick", u), pt[u], 0);
      check_idle(u, "async");
    end
    run_cycles(3);
    reset = 1'b1;
    run_cycles(300);

    $display("[tb] stop both units");
    en[1] = 1'b0;
    run_until_stop(1, 300);
    en[0] = 1'b0;
    run_until_stop(0, 300);
    run_cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
# vga_timing_controller

Sequences the VGA raster for the display path. From the system clock it derives a one-cycle pixel-enable tick and steps horizontal and vertical phase state machines. It drives hsync, vsync, blanking and pixel coordinates to the pixel generator. Start and stop are frame-aligned: a stop request never truncates a frame on the monitor.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- DIV, 2, in_clk cycles per pixel; legal range is 1 or greater
- in_clk  input  1  system clock; all logic runs on its rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run request, level-sensitive
- pix_tick  output  1  one in_clk-cycle pulse per pixel
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- blank_n  output  1  high only inside the active area
- x  output  XW  pixel column, XW = $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)
- y  output  YW  line number, YW = $clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)
- frame_start  output  1  pulse coincident with the pix_tick at (0,0)
- running  output  1  high while frames are being produced

## Operation
- Horizontal FSM states: H_ACT, H_FP, H_SYN, H_BP.
- Vertical FSM states: V_ACT, V_FP, V_SYN, V_BP.
- Both FSMs hold a phase counter. Phase counters and x/y advance only on pix_tick.
- At the end of each phase the horizontal FSM moves to the next state and reloads its phase counter.
- Leaving H_BP wraps x to 0 and produces one vertical step. y increments, and leaving V_BP wraps y to 0.
- x counts 0..H_TOTAL-1 continuously and y counts 0..V_TOTAL-1, where H_TOTAL and V_TOTAL are the sums of the four phases. Both wrap with no overflow.
- hsync is 0 exactly in H_SYN. vsync is 0 exactly in V_SYN.
- blank_n = (H_ACT && V_ACT).
- Run control:
  - Idle with enable=1: start.
  - Running with enable=0: the current frame completes. The controller stops at the wrap from (H_TOTAL-1, V_TOTAL-1). At that point running falls and pix_tick halts.
  - enable reasserted before that wrap cancels the stop. There is no gap.
- Reset values: pix_tick=0, hsync=1, vsync=1, blank_n=0, x=0, y=0, frame_start=0, running=0. Both FSMs reset to their ACT state.
- Reset asserted mid-frame returns all outputs to their reset values immediately (asynchronous).

## Timing
- enable sampled high while idle: running=1 on the next edge.
- The first pix_tick occurs DIV cycles after running rises. It is at x=0, y=0, with frame_start=1.
- pix_tick period is exactly DIV in_clk cycles. DIV=1 gives pix_tick held high.
- x, y, hsync, vsync and blank_n change on the in_clk edge following a pix_tick. They are stable for DIV cycles.
- Frame period is H_TOTAL*V_TOTAL*DIV in_clk cycles: 800*525*2 = 840000 with the defaults.
- Stop: running deasserts on the edge after the final pix_tick of the frame. Outputs return to reset values at that edge.

## Configuration
- VGA_TIMING_REG_OUT_EN defined:
  - hsync, vsync, blank_n, x and y pass through one extra register, updated on pix_tick.
  - All five lag by one pixel.
  - frame_start is delayed identically to stay aligned.
- VGA_TIMING_REG_OUT_EN undefined: outputs come directly from the FSM and counter registers, with the timing above.

## Structure
- Package vga_timing_pkg holds:
  - the h_phase_t and v_phase_t enums
  - the 640x480@60 default constants
  - H_TOTAL and V_TOTAL computation functions
- Sub-module pixel_tick_gen holds the DIV counter:
  - inputs: in_clk, reset, run
  - output: tick
  - its counter clears when run=0.

## Test plan
- Defaults, enable=1 from reset: first pix_tick 2 cycles after running rises. Required: hsync low for 96 ticks starting at x=656, and vsync low for lines y=490..491.
- One frame, defaults: 840000 in_clk cycles between frame_start pulses, and 307200 ticks with blank_n=1.
- enable dropped at y=100: the frame completes through y=524, x=799, then running=0 and pix_tick stops. No partial frame.
- enable dropped at y=100, reasserted at y=300: frame_start recurs at exactly 840000 cycles. running stays 1.
- reset pulsed mid-line at x=300: outputs are at reset values during reset. Restart begins at (0,0).
- DIV=1 and H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V all=2: x sequence 0..13 wraps. hsync is low at x=10..11. Run this with VGA_TIMING_REG_OUT_EN both defined and undefined; the defined build shows a one-tick lag.
